// File: rtl/s2_hazard_ctrl_pkg.sv
// Shared core constants for the S2 hazard controller: opcodes, forwarding-select
// encodings, controller FSM states and the forwarding priority helper.
package s2_hazard_ctrl_pkg;

    localparam logic [6:0] OP_LUI       = 7'b0110111;
    localparam logic [6:0] OP_AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_ARI_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_ARI_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_CSR       = 7'b1110011;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    localparam logic [1:0] FWD_S3  = 2'b00;
    localparam logic [1:0] FWD_WBD = 2'b01;
    localparam logic [1:0] FWD_RF  = 2'b10;

    typedef enum logic [1:0] {
        StBoot    = 2'b00,
        StRun     = 2'b01,
        StLdStall = 2'b10
    } hz_state_e;

    // The younger producer (S2) wins over the older one (S3).
    function automatic logic [1:0] fwd_select(
        input logic       used,
        input logic [4:0] rs,
        input logic [4:0] s2_rd,
        input logic       s2_wen,
        input logic [4:0] s3_rd,
        input logic       s3_wen
    );
        if (used && s2_wen && (rs == s2_rd)) begin
            return FWD_S3;
        end else if (used && s3_wen && (rs == s3_rd)) begin
            return FWD_WBD;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/s2_hazard_ctrl_rs_usage_decode.sv
// Combinational register-usage decode of the S1 instruction: which sources are
// read, whether rd is written (never for x0) and whether it is a load.
module s2_hazard_ctrl_rs_usage_decode
    import s2_hazard_ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic        rs1_used_o,
    output logic        rs2_used_o,
    output logic        rd_wen_o,
    output logic        is_load_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o
);

    logic [6:0] opcode;
    logic       writes_rd;
    logic       unused_instr;

    assign opcode       = instr_i[6:0];
    assign rd_o         = instr_i[11:7];
    assign rs1_o        = instr_i[19:15];
    assign rs2_o        = instr_i[24:20];
    assign unused_instr = ^{instr_i[31:25], instr_i[14:12]};

    always_comb begin
        writes_rd  = 1'b0;
        rs1_used_o = 1'b0;
        rs2_used_o = 1'b0;
        is_load_o  = 1'b0;
        unique case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: writes_rd = 1'b1;
            OP_JALR, OP_ARI_ITYPE: begin
                writes_rd  = 1'b1;
                rs1_used_o = 1'b1;
            end
            OP_LOAD: begin
                writes_rd  = 1'b1;
                rs1_used_o = 1'b1;
                is_load_o  = 1'b1;
            end
            OP_ARI_RTYPE: begin
                writes_rd  = 1'b1;
                rs1_used_o = 1'b1;
                rs2_used_o = 1'b1;
            end
            OP_BRANCH, OP_STORE: begin
                rs1_used_o = 1'b1;
                rs2_used_o = 1'b1;
            end
            OP_CSR: rs1_used_o = 1'b1;
            default: ;
        endcase
    end

    // An x0 destination is treated as a non-writer so it can never match a source.
    assign rd_wen_o = writes_rd && (rd_o != 5'd0);

endmodule

// File: rtl/s2_hazard_ctrl.sv
// Hazard controller for the 3-stage core: registered S2 forwarding selects,
// one-cycle load-use stall, redirect/boot bubbles, and cycle/instret counters.
module s2_hazard_ctrl
    import s2_hazard_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction_s1,
    input  logic        redirect_s2,
    output logic        stall_s1,
    output logic        bubble_s2,
    output logic [1:0]  rs1_sel,
    output logic [1:0]  rs2_sel,
    output logic        valid_s2,
    output logic        valid_s3,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    logic       dec_rs1_used, dec_rs2_used, dec_rd_wen, dec_is_load;
    logic [4:0] dec_rd, dec_rs1, dec_rs2;
    logic       load_use;

    hz_state_e   state_q, state_d;
    logic [4:0]  s2_rd_q, s2_rd_d, s3_rd_q, s3_rd_d;
    logic        s2_wen_q, s2_wen_d, s3_wen_q, s3_wen_d;
    logic        s2_load_q, s2_load_d;
    logic        s2_valid_q, s2_valid_d, s3_valid_q, s3_valid_d;
    logic [1:0]  rs1_sel_q, rs1_sel_d, rs2_sel_q, rs2_sel_d;
    logic [31:0] cycle_q, cycle_d, instret_q, instret_d;

    s2_hazard_ctrl_rs_usage_decode u_rs_usage_decode (
        .instr_i    (instruction_s1),
        .rs1_used_o (dec_rs1_used),
        .rs2_used_o (dec_rs2_used),
        .rd_wen_o   (dec_rd_wen),
        .is_load_o  (dec_is_load),
        .rd_o       (dec_rd),
        .rs1_o      (dec_rs1),
        .rs2_o      (dec_rs2)
    );

    assign load_use = s2_load_q && s2_wen_q &&
                      ((dec_rs1_used && (dec_rs1 == s2_rd_q)) ||
                       (dec_rs2_used && (dec_rs2 == s2_rd_q)));

    always_comb begin
        bubble_s2 = 1'b1;
        stall_s1  = 1'b0;
        state_d   = StRun;
        unique case (state_q)
            StBoot: begin
                bubble_s2 = 1'b1;
                stall_s1  = 1'b0;
                state_d   = StRun;
            end
            StRun, StLdStall: begin
                // A redirect kills the consumer, so it overrides the load-use hold.
                bubble_s2 = load_use || redirect_s2;
                stall_s1  = load_use && !redirect_s2;
                state_d   = stall_s1 ? StLdStall : StRun;
            end
            default: ;
        endcase
    end

    always_comb begin
        s3_rd_d    = s2_rd_q;
        s3_wen_d   = s2_wen_q;
        s3_valid_d = s2_valid_q;
        if (bubble_s2) begin
            s2_rd_d    = 5'd0;
            s2_wen_d   = 1'b0;
            s2_load_d  = 1'b0;
            s2_valid_d = 1'b0;
            rs1_sel_d  = FWD_RF;
            rs2_sel_d  = FWD_RF;
        end else begin
            s2_rd_d    = dec_rd;
            s2_wen_d   = dec_rd_wen;
            s2_load_d  = dec_is_load;
            s2_valid_d = 1'b1;
            rs1_sel_d  = fwd_select(dec_rs1_used, dec_rs1, s2_rd_q, s2_wen_q, s3_rd_q, s3_wen_q);
            rs2_sel_d  = fwd_select(dec_rs2_used, dec_rs2, s2_rd_q, s2_wen_q, s3_rd_q, s3_wen_q);
        end
        cycle_d   = cycle_q + 32'd1;
        instret_d = instret_q + {31'd0, s3_valid_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StBoot;
            s2_rd_q    <= 5'd0;
            s2_wen_q   <= 1'b0;
            s2_load_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_rd_q    <= 5'd0;
            s3_wen_q   <= 1'b0;
            s3_valid_q <= 1'b0;
            rs1_sel_q  <= FWD_RF;
            rs2_sel_q  <= FWD_RF;
            cycle_q    <= 32'd0;
            instret_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            s2_rd_q    <= s2_rd_d;
            s2_wen_q   <= s2_wen_d;
            s2_load_q  <= s2_load_d;
            s2_valid_q <= s2_valid_d;
            s3_rd_q    <= s3_rd_d;
            s3_wen_q   <= s3_wen_d;
            s3_valid_q <= s3_valid_d;
            rs1_sel_q  <= rs1_sel_d;
            rs2_sel_q  <= rs2_sel_d;
            cycle_q    <= cycle_d;
            instret_q  <= instret_d;
        end
    end

    assign rs1_sel     = rs1_sel_q;
    assign rs2_sel     = rs2_sel_q;
    assign valid_s2    = s2_valid_q;
    assign valid_s3    = s3_valid_q;
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;

endmodule

// File: doc/s2_hazard_ctrl.md
# s2_hazard_ctrl

Pipeline hazard controller for the 3-stage core: S1 fetch/decode, S2 execute, S3 memory/writeback. It tracks destination-register state for the instructions in S2 and S3 and produces three kinds of control. Registered forwarding selects feed the S2 operand muxes. A one-cycle load-use stall holds S1. Bubbles are injected into S2 after reset and on control-flow redirects. It also keeps retired-instruction and cycle counters for the CSR file.

## Interface
- Parameters: none.
- Ports:
- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-high
- instruction_s1  in  32  instruction currently in S1; enters S2 at the next edge unless stalled or killed
- redirect_s2  in  1  S2 resolved a JAL, a JALR or a taken branch this cycle
- stall_s1  out  1  hold PC and the S1 instruction register this cycle
- bubble_s2  out  1  load NOP (32'h0000_0013) into the S2 instruction register at the next edge
- rs1_sel, rs2_sel  out  2  registered S2 operand selects:
  - 2'b00: S3 writeback data
  - 2'b01: delayed writeback register (last cycle's writeback)
  - 2'b10: regfile
- valid_s2, valid_s3  out  1  stage holds a real (non-bubble) instruction
- cycle_cnt, instret_cnt  out  32  free-running cycle count; count of valid S3 retirements

## Operation
- Rules for decoding instruction_s1:
  - Writes rd: LUI, AUIPC, JAL, JALR, LOAD, ARI_RTYPE, ARI_ITYPE. CSR does not write rd.
  - Uses rs1: JALR, BRANCH, STORE, LOAD, ARI_*, CSR.
  - Uses rs2: BRANCH, STORE, ARI_RTYPE.
  - rd = x0 never matches a source register.
- Tracking registers:
  - s2_{rd, wen, load, valid} and s3_{rd, wen, valid}.
  - Every edge: S3 ← S2.
  - S2 ← decode(instruction_s1) when bubble_s2=0; otherwise S2 ← NOP (wen=0, valid=0).
- Forwarding, computed from instruction_s1 and registered:
  - Applied only on edges where the instruction advances; on bubble edges the selects load 2'b10.
  - A source matching S2 (s2_wen) → 2'b00.
  - Else a source matching S3 (s3_wen) → 2'b01.
  - Else → 2'b10.
  - S2 match has priority over S3 match.
- Load-use hazard:
  - Condition: s2_load & s2_wen, and a used rs of instruction_s1 equals s2_rd.
  - Response: stall_s1=1 and bubble_s2=1 for one cycle.
  - The next cycle re-evaluates with the load now in S3, so the consumer advances with select 2'b01.
- Redirect: redirect_s2=1 → bubble_s2=1 and stall_s1=0; the wrong-path S1 instruction is killed. Redirect overrides a load-use stall in the same cycle.
- FSM states:
  - BOOT: bubble_s2=1, stall_s1=0; always → RUN.
  - RUN: bubble_s2 = load-use OR redirect; stall_s1 = load-use AND NOT redirect. → LDSTALL on a stall, otherwise stays in RUN.
  - LDSTALL: evaluates exactly like RUN (re-stall cannot occur, because S2 holds a bubble). → RUN, or → LDSTALL again only if a new hazard exists.
- Counters:
  - cycle_cnt increments every cycle after reset.
  - instret_cnt increments when valid_s3=1.
  - Both wrap at 2^32.

## Timing
- Reset values, asynchronous: state=BOOT, all tracking valid/wen=0, rs1_sel=rs2_sel=2'b10, valid_s2=valid_s3=0, counters=0. While rst=1: stall_s1=0 and bubble_s2=1.
- stall_s1 and bubble_s2 are combinational from state, instruction_s1, the tracking registers and redirect_s2, all in the same cycle. redirect_s2 → bubble_s2 has zero latency.
- rs*_sel are valid during the cycle the instruction occupies S2, i.e. registered one edge after the decision in S1.
- A load-use stall costs exactly one cycle.
- A redirect costs exactly one killed instruction.
- Reset asserted mid-stall or mid-redirect: everything returns to its reset value immediately.

## Structure
- Opcode and funct3 macros come from the shared opcode header already used by the core.
- FSM state encodings (BOOT, RUN, LDSTALL) and the forwarding-select encodings (FWD_S3=2'b00, FWD_WBD=2'b01, FWD_RF=2'b10) go in the shared core constants package, so the S2 operand muxes use the same names.
- One sub-module: rs_usage_decode (combinational: instruction → rs1_used, rs2_used, rd_wen, is_load, rd).

## Test plan
- Reset release, then ADDI x1,x0,5 in S1 → first cycle bubble_s2=1, then valid_s2=1, rs1_sel=2'b10, cycle_cnt=1 after the first edge.
- ADDI x1,x0,5 followed by ADD x2,x1,x1 → ADD in S2 with rs1_sel=rs2_sel=2'b00 and no stall. With one unrelated instruction between them → 2'b01.
- LW x3,0(x0) followed by ADD x4,x3,x0 → one cycle of stall_s1=1 and bubble_s2=1, then ADD in S2 with rs1_sel=2'b01. instret_cnt is unaffected by the bubble.
- LW x3 in S2 with a consumer in S1, plus redirect_s2=1 in the same cycle → stall_s1=0, bubble_s2=1; the consumer is killed and never retires.
- Writer to x0 (ADDI x0,x0,1) followed by ADD x5,x0,x0 → selects stay 2'b10.
- rst pulsed while in LDSTALL → state=BOOT, rs*_sel=2'b10 and counters=0 immediately, without waiting for a clock.
